// File: rtl/key_toggle_debouncer.sv
// rtl/key_toggle_debouncer.sv - push-button synchroniser, debouncer and press toggle
// Emits clean level, press/release strobes, a toggling mux select and a press counter.
module key_toggle_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit SEL_INIT        = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       KEY_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       sel,
  output logic [7:0] press_count
);

  localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    UP      = 2'd0,
    DB_DOWN = 2'd1,
    DOWN    = 2'd2,
    DB_UP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             s1;
  logic             s2;
  logic             press_nx;
  logic             release_nx;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    case (state)
      UP: begin
        if (s2) begin
          state_nx = DB_DOWN;
          cnt_nx   = CNT_W'(1);
        end else begin
          cnt_nx = '0;
        end
      end
      DB_DOWN: begin
        if (!s2) begin
          state_nx = UP;
          cnt_nx   = '0;
        end else if (cnt == DB_LIM) begin
          state_nx = DOWN;
          cnt_nx   = '0;
          press_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DOWN: begin
        if (!s2) begin
          state_nx = DB_UP;
          cnt_nx   = CNT_W'(1);
        end
      end
      DB_UP: begin
        if (s2) begin
          state_nx = DOWN;
          cnt_nx   = '0;
        end else if (cnt == DB_LIM) begin
          state_nx   = UP;
          cnt_nx     = '0;
          release_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = UP;
        cnt_nx   = '0;
      end
    endcase
  end

  // The key is inverted before synchronising so s2 reads 1 while pressed.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= UP;
      cnt           <= '0;
      s1            <= 1'b0;
      s2            <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      sel           <= SEL_INIT;
      press_count   <= 8'd0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      s1            <= ~KEY_n;
      s2            <= s1;
      pressed       <= (state_nx == DOWN) || (state_nx == DB_UP);
      press_pulse   <= press_nx;
      release_pulse <= release_nx;
      if (press_nx) begin
        sel         <= ~sel;
        press_count <= press_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_toggle_debouncer.sv
// tb/tb_key_toggle_debouncer.sv - self-checking bench for key_toggle_debouncer
module tb_key_toggle_debouncer;
  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       KEY_n = 1'b1;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       sel;
  logic [7:0] press_count;

  int errors = 0;
  int checks = 0;

  key_toggle_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(8),
    .SEL_INIT(1'b0)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .KEY_n(KEY_n),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .sel(sel),
    .press_count(press_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference: raw key delayed by a two-deep sync pipe; the accepted level flips
  // once D+1 consecutive pipe outputs disagree with it.
  logic       m_s1 = 0, m_s2 = 0, m_acc = 0, m_pp = 0, m_rp = 0, m_sel = 0;
  logic [7:0] m_cnt = 0;
  int         m_run = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic key, input logic rst);
    logic smp;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_run = 0;
      m_pp = 0; m_rp = 0; m_sel = 0; m_cnt = 0;
    end else begin
      smp  = m_s2;
      m_s2 = m_s1;
      m_s1 = ~key;
      m_pp = 0;
      m_rp = 0;
      if (smp != m_acc) begin
        m_run++;
        if (m_run == D + 1) begin
          m_acc = smp;
          m_run = 0;
          if (smp) begin
            m_pp  = 1;
            m_sel = ~m_sel;
            m_cnt = m_cnt + 8'd1;
          end else begin
            m_rp = 1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic key, input logic rst);
    KEY_n = key;
    reset = rst;
    @(posedge CLOCK_50);
    model_update(key, rst);
    #1;
    check("pressed", {7'd0, pressed}, {7'd0, m_acc});
    check("press_pulse", {7'd0, press_pulse}, {7'd0, m_pp});
    check("release_pulse", {7'd0, release_pulse}, {7'd0, m_rp});
    check("sel", {7'd0, sel}, {7'd0, m_sel});
    check("press_count", press_count, m_cnt);
    if (press_pulse && release_pulse) check("pulse_overlap", 8'd1, 8'd0);
  endtask

  // Holds the key level for n edges; reports the first edge index with each DUT strobe.
  task automatic hold(input logic key, input int n, output int pp_at, output int rp_at);
    pp_at = -1;
    rp_at = -1;
    for (int i = 0; i < n; i++) begin
      step(key, 1'b0);
      if (press_pulse && pp_at < 0) pp_at = i;
      if (release_pulse && rp_at < 0) rp_at = i;
    end
  endtask

  initial begin
    int   pp, rp, pp_tot, rp_tot;
    logic sel_before;
    logic [7:0] cnt_before;

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("reset_pressed", {7'd0, pressed}, 8'd0);
    check("reset_sel", {7'd0, sel}, 8'd0);
    check("reset_count", press_count, 8'd0);

    hold(1'b1, 20, pp, rp);
    check("idle_no_press_pulse", pp[7:0], 8'hFF);
    check("idle_no_release_pulse", rp[7:0], 8'hFF);

    hold(1'b0, 20, pp, rp);
    check("press_latency", pp[7:0], 8'(D + 2));
    check("held_pressed", {7'd0, pressed}, 8'd1);
    check("held_sel", {7'd0, sel}, 8'd1);
    check("held_count", press_count, 8'd1);
    hold(1'b1, 20, pp, rp);
    check("release_latency", rp[7:0], 8'(D + 2));

    sel_before = sel;
    cnt_before = press_count;
    pp_tot = 0;
    hold(1'b0, 3, pp, rp); if (pp >= 0) pp_tot++;
    hold(1'b1, 1, pp, rp); if (pp >= 0) pp_tot++;
    hold(1'b0, 2, pp, rp); if (pp >= 0) pp_tot++;
    hold(1'b1, 12, pp, rp); if (pp >= 0) pp_tot++;
    check("bounce_no_pulse", pp_tot[7:0], 8'd0);
    check("bounce_pressed", {7'd0, pressed}, 8'd0);
    check("bounce_sel", {7'd0, sel}, {7'd0, sel_before});
    check("bounce_count", press_count, cnt_before);

    rp_tot = 0;
    for (int k = 0; k < 3; k++) begin
      hold(1'b0, 10, pp, rp);
      check("cycle_sel", {7'd0, sel}, {7'd0, (k % 2 == 0) ? ~sel_before : sel_before});
      hold(1'b1, 10, pp, rp);
      check("cycle_release_latency", rp[7:0], 8'(D + 2));
      if (rp >= 0) rp_tot++;
    end
    check("cycle_release_count", rp_tot[7:0], 8'd3);
    check("cycle_count", press_count, cnt_before + 8'd3);

    pp = -1;
    for (int e = 0; e < 20; e++) begin
      step(1'b0, (e == 4 || e == 5));
      if (press_pulse && pp < 0) pp = e;
    end
    check("reset_midpress_latency", pp[7:0], 8'd12);
    check("reset_midpress_count", press_count, 8'd1);
    hold(1'b1, 10, pp, rp);

    step(1'b1, 1'b1);
    for (int k = 0; k < 256; k++) begin
      hold(1'b0, 8, pp, rp);
      hold(1'b1, 8, pp, rp);
    end
    check("wrap_count", press_count, 8'd0);
    check("wrap_sel", {7'd0, sel}, 8'd0);

    for (int seg = 0; seg < 120; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = (($urandom & 3) == 0) ? $urandom_range(D, D + 6) : $urandom_range(1, D + 2);
      for (int i = 0; i < len; i++) step(lvl, ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
